tdm_demux4: RTL and testbench

- Receive end of the 4:1 time-division link built from the inverting 4-input mux cell (one of i0..i3 selected by s1/s0, output complemented).
- Drives the slot selects {s1,s0} and samples the serial mux output.
- Rebuilds each 4-bit frame in slot order and presents it on a valid/ready output with a one-word holding buffer.
- Detects frame-alignment errors and output overruns.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_out_buf.sv | 33 +++
 rtl/tdm_demux4.sv | 100 ++++++++++
 tb/tb_tdm_demux4.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the 4:1 TDM receive link: slot index, frame word and
// receiver lock state.
package tdm_pkg;

  typedef logic [1:0] slot_t;
  typedef logic [3:0] word_t;

  localparam slot_t SLOT_LAST = 2'd3;

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  function automatic slot_t next_slot(input slot_t s);
    return (s == SLOT_LAST) ? slot_t'(0) : slot_t'(s + slot_t'(1));
  endfunction

endpackage

// File: rtl/tdm_out_buf.sv
// Single-entry valid/ready holding register for received frame words.
// A load accepted while the entry is full and not draining is dropped.
module tdm_out_buf
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  word_t word,
  input  logic  q_ready,
  output word_t q,
  output logic  q_valid,
  output logic  drop
);

  logic take;

  assign take = load & (~q_valid | q_ready);
  assign drop = load & q_valid & ~q_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (take) begin
      q       <= word;
      q_valid <= 1'b1;
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 inverting-mux TDM link: drives the slot selects,
// captures the serial bit per slot and rebuilds 4-bit frames.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter bit DATA_INV = 1'b1,
  parameter bit REQ_SYNC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sync,
  input  logic       d,
  output logic       s0,
  output logic       s1,
  output logic       locked,
  output logic [3:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       err,
  output logic       ovf
);

  state_t      state;
  slot_t       slot;
  logic [2:0]  asm_q;
  logic        cap_bit;
  logic        mid_sync;
  logic        word_done;
  word_t       done_word;
  logic        drop;

  assign cap_bit = d ^ DATA_INV;
  assign s0      = slot[0];
  assign s1      = slot[1];
  assign locked  = (state == LOCK);

  // A mid-frame resync wins over a slot-3 completion in the same cycle.
  always_comb begin
    mid_sync  = 1'b0;
    word_done = 1'b0;
    done_word = {cap_bit, asm_q};
    if (en && state == LOCK) begin
      mid_sync  = sync && (slot != slot_t'(0));
      word_done = !mid_sync && (slot == SLOT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ_SYNC ? HUNT : LOCK;
      slot  <= '0;
      asm_q <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      err <= 1'b0;
      ovf <= drop;
      if (en) begin
        case (state)
          HUNT: begin
            if (sync) begin
              state <= LOCK;
              asm_q <= {2'b00, cap_bit};
              slot  <= slot_t'(1);
            end
          end
          LOCK: begin
            if (mid_sync) begin
              err   <= 1'b1;
              asm_q <= {2'b00, cap_bit};
              slot  <= slot_t'(1);
            end else begin
              case (slot)
                2'd0:    asm_q[0] <= cap_bit;
                2'd1:    asm_q[1] <= cap_bit;
                2'd2:    asm_q[2] <= cap_bit;
                default: ;
              endcase
              slot <= next_slot(slot);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  tdm_out_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (word_done),
    .word    (done_word),
    .q_ready (q_ready),
    .q       (q),
    .q_valid (q_valid),
    .drop    (drop)
  );

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus pushes expected words, a
// negedge monitor pops and compares on every accepted output word.
module tb_tdm_demux4;
  import tdm_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, sync, d, q_ready;
  logic       s0, s1, locked, q_valid, err, ovf;
  logic [3:0] q;
  logic       s0_b, s1_b, locked_b, q_valid_b, err_b, ovf_b;
  logic [3:0] q_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  word_t       exp_q[$];
  logic        prev_hold = 1'b0;
  word_t       prev_q    = '0;
  int unsigned ovf_cnt   = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.DATA_INV(1'b1), .REQ_SYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .d(d),
    .s0(s0), .s1(s1), .locked(locked), .q(q), .q_valid(q_valid),
    .q_ready(q_ready), .err(err), .ovf(ovf)
  );

  tdm_demux4 #(.DATA_INV(1'b0), .REQ_SYNC(1'b0)) dut_nosync (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .d(d),
    .s0(s0_b), .s1(s1_b), .locked(locked_b), .q(q_b), .q_valid(q_valid_b),
    .q_ready(q_ready), .err(err_b), .ovf(ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic sy, input logic dd);
    en = e; sync = sy; d = dd;
    @(posedge clk);
    #1;
  endtask

  // d carries the complemented transmitter bit; push before the completing edge.
  task automatic send_word(input word_t w, input bit first_sync, input bit expect_out);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && expect_out) exp_q.push_back(w);
      cyc(1'b1, first_sync && k == 0, ~w[k]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        check("q_stable_valid", {31'd0, q_valid}, 32'd1);
        check("q_stable_data", {28'd0, q}, {28'd0, prev_q});
      end
      if (ovf) ovf_cnt++;
      if (q_valid && q_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", q, $time);
        end else begin
          check("word", {28'd0, q}, {28'd0, exp_q.pop_front()});
        end
      end
    end
    prev_hold <= !rst && q_valid && !q_ready;
    prev_q    <= q;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned ovf_base;
    rst = 1'b1; en = 1'b0; sync = 1'b0; d = 1'b0; q_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_slot", {30'd0, s1, s0}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_err_ovf", {30'd0, err, ovf}, 32'd0);
    check("rst_locked_nosync", {31'd0, locked_b}, 32'd1);
    rst = 1'b0;

    // Hunt: no sync, nothing captured
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'($urandom));
      check("hunt_slot", {30'd0, s1, s0}, 32'd0);
    end
    check("hunt_locked", {31'd0, locked}, 32'd0);
    check("hunt_q_valid", {31'd0, q_valid}, 32'd0);

    // Basic frame 1010 with slot stepping
    exp_q.push_back(4'b1010);
    cyc(1'b1, 1'b1, 1'b1);
    check("lock_after_sync", {31'd0, locked}, 32'd1);
    check("basic_slot1", {30'd0, s1, s0}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    check("basic_slot2", {30'd0, s1, s0}, 32'd2);
    cyc(1'b1, 1'b0, 1'b1);
    check("basic_slot3", {30'd0, s1, s0}, 32'd3);
    check("basic_valid_late", {31'd0, q_valid}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("basic_slot_wrap", {30'd0, s1, s0}, 32'd0);
    check("basic_q_valid", {31'd0, q_valid}, 32'd1);
    check("basic_q", {28'd0, q}, 32'hA);
    cyc(1'b0, 1'b0, 1'b0);
    check("basic_drained", {31'd0, q_valid}, 32'd0);

    // en gap between slots 1 and 2
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'($urandom));
      check("gap_slot_hold", {30'd0, s1, s0}, 32'd2);
      check("gap_err", {31'd0, err}, 32'd0);
    end
    exp_q.push_back(4'b1010);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    check("gap_q", {28'd0, q}, 32'hA);
    check("gap_no_err", {31'd0, err}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Misalignment: sync arrives at slot 2
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("mis_pre_slot", {30'd0, s1, s0}, 32'd2);
    cyc(1'b1, 1'b1, 1'b1);
    check("mis_err_pulse", {31'd0, err}, 32'd1);
    check("mis_slot_restart", {30'd0, s1, s0}, 32'd1);
    check("mis_no_word", {31'd0, q_valid}, 32'd0);
    check("mis_no_ovf", {31'd0, ovf}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    check("mis_err_clear", {31'd0, err}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    exp_q.push_back(4'b0000);
    cyc(1'b1, 1'b0, 1'b1);
    check("mis_q", {28'd0, q}, 32'h0);
    check("mis_q_valid", {31'd0, q_valid}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0);

    // Backpressure: three frames, only the first survives
    q_ready = 1'b0;
    ovf_base = ovf_cnt;
    send_word(4'h3, 1'b1, 1'b1);
    check("bp_first_q", {28'd0, q}, 32'h3);
    check("bp_first_ovf", {31'd0, ovf}, 32'd0);
    send_word(4'h5, 1'b1, 1'b0);
    check("bp_ovf1", {31'd0, ovf}, 32'd1);
    send_word(4'h9, 1'b1, 1'b0);
    check("bp_ovf2", {31'd0, ovf}, 32'd1);
    check("bp_q_held", {28'd0, q}, 32'h3);
    cyc(1'b0, 1'b0, 1'b0);
    check("bp_ovf_count", ovf_cnt - ovf_base, 32'd2);
    q_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("bp_drained", {31'd0, q_valid}, 32'd0);

    // Full throughput, back-to-back frames
    send_word(4'hC, 1'b1, 1'b1);
    check("tp_q0", {28'd0, q}, 32'hC);
    send_word(4'h6, 1'b0, 1'b1);
    check("tp_q1", {28'd0, q}, 32'h6);
    check("tp_valid1", {31'd0, q_valid}, 32'd1);
    check("tp_no_ovf", {31'd0, ovf}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset mid-frame with a buffered word
    q_ready = 1'b0;
    send_word(4'h7, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("rstmid_pre_slot", {30'd0, s1, s0}, 32'd2);
    check("rstmid_pre_valid", {31'd0, q_valid}, 32'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("rstmid_q_valid", {31'd0, q_valid}, 32'd0);
    check("rstmid_q", {28'd0, q}, 32'd0);
    check("rstmid_slot", {30'd0, s1, s0}, 32'd0);
    check("rstmid_locked", {31'd0, locked}, 32'd0);
    rst = 1'b0;
    q_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    send_word(4'b0110, 1'b1, 1'b1);
    check("post_rst_q", {28'd0, q}, 32'h6);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
